// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM port-A signal bundle for bram_port_arbiter.
// slave = arbiter side, master = requesters + BRAM wrapper side.
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req0;
    logic                  req1;
    logic [DATA_W/8-1:0]   we0;
    logic [DATA_W/8-1:0]   we1;
    logic [ADDR_W-1:0]     addr0;
    logic [ADDR_W-1:0]     addr1;
    logic [DATA_W-1:0]     wdata0;
    logic [DATA_W-1:0]     wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_W-1:0]     rdata0;
    logic [DATA_W-1:0]     rdata1;
    logic                  bram_en;
    logic [DATA_W/8-1:0]   bram_we;
    logic [ADDR_W-1:0]     bram_addr;
    logic [DATA_W-1:0]     bram_din;
    logic [DATA_W-1:0]     bram_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin 2:1 arbiter onto BRAM port A; optional grant counters under BRAM_ARB_PERF_EN.
// Latency: grant comb in N, bram_en in N+1, read return in N+2+RD_LAT.
// Backpressure: a losing requester holds req until gnt; worst-case wait is one cycle.
module bram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    bram_port_arbiter_if.slave   bus
`ifdef BRAM_ARB_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [31:0]          perf_cnt0,
    output logic [31:0]          perf_cnt1
`endif
);
    localparam int BE_W = DATA_W / 8;

    logic                last;
    logic                gnt0_c;
    logic                gnt1_c;
    logic                any_gnt;
    logic                is_read;
    logic [BE_W-1:0]     we_sel;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;

    logic                en_q;
    logic [BE_W-1:0]     we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   din_q;
    logic [RD_LAT:0]     pipe_vld;
    logic [RD_LAT:0]     pipe_id;
    logic                rvalid0_q;
    logic                rvalid1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    // Grants are gated by reset so nothing is accepted while rsta_n is low.
    assign gnt0_c  = rsta_n & bus.req0 & (~bus.req1 | last);
    assign gnt1_c  = rsta_n & bus.req1 & (~bus.req0 | ~last);
    assign any_gnt = gnt0_c | gnt1_c;

    always_comb begin
        we_sel    = bus.we0;
        addr_sel  = bus.addr0;
        wdata_sel = bus.wdata0;
        if (gnt1_c) begin
            we_sel    = bus.we1;
            addr_sel  = bus.addr1;
            wdata_sel = bus.wdata1;
        end
    end

    assign is_read = any_gnt & (we_sel == '0);

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            last      <= 1'b1;
            en_q      <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            pipe_vld  <= '0;
            pipe_id   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (any_gnt) begin
                last   <= gnt1_c;
                addr_q <= addr_sel;
                din_q  <= wdata_sel;
            end
            en_q <= any_gnt;
            we_q <= any_gnt ? we_sel : '0;

            // Stage 0 aligns with bram_en; stage RD_LAT aligns with valid douta.
            pipe_vld <= {pipe_vld[RD_LAT-1:0], is_read};
            pipe_id  <= {pipe_id[RD_LAT-1:0], gnt1_c};

            rvalid0_q <= pipe_vld[RD_LAT] & ~pipe_id[RD_LAT];
            rvalid1_q <= pipe_vld[RD_LAT] &  pipe_id[RD_LAT];
            if (pipe_vld[RD_LAT] && !pipe_id[RD_LAT]) rdata0_q <= bus.bram_dout;
            if (pipe_vld[RD_LAT] &&  pipe_id[RD_LAT]) rdata1_q <= bus.bram_dout;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.bram_en   = en_q;
    assign bus.bram_we   = we_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;

`ifdef BRAM_ARB_PERF_EN
    // Clear has priority over a same-cycle increment; counters saturate.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            perf_cnt0 <= '0;
            perf_cnt1 <= '0;
        end else if (perf_clr) begin
            perf_cnt0 <= '0;
            perf_cnt1 <= '0;
        end else begin
            if (gnt0_c && perf_cnt0 != 32'hFFFF_FFFF) perf_cnt0 <= perf_cnt0 + 32'd1;
            if (gnt1_c && perf_cnt1 != 32'hFFFF_FFFF) perf_cnt1 <= perf_cnt1 + 32'd1;
        end
    end
`endif
endmodule
